// File: rtl/cas_fsk_player.sv
// Cassette image player: streams bytes from a synchronous tape RAM and regenerates
// the framed FSK tape waveform, with prefetch, pause/resume and end-of-image detection.
//
// state    | meaning
// ---------+------------------------------------------------
// EMPTY    | image length is zero, play ignored
// STOPPED  | at position 0, nothing loaded, waiting for play
// LD_RD    | read strobe for the first byte is out
// LD_CAP   | first byte captured into the shift register
// RUN      | emitting bits
// PAUSED   | play dropped mid-stream, counters frozen
// END      | last frame fully emitted, waiting for rewind
module cas_fsk_player #(
   parameter int   ADDR_W     = 18,
   parameter int   HALF0      = 17775,
   parameter int   STOP_BITS  = 2,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              ce,
   input  logic              play,
   input  logic              rewind,
   input  logic [ADDR_W-1:0] len,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [7:0]        mem_data,
   output logic              tape_o,
   output logic [ADDR_W-1:0] pos,
   output logic [2:0]        status
);
   localparam logic [2:0] S_EMPTY   = 3'd0;
   localparam logic [2:0] S_STOPPED = 3'd1;
   localparam logic [2:0] S_RUN     = 3'd2;
   localparam logic [2:0] S_PAUSED  = 3'd3;
   localparam logic [2:0] S_END     = 3'd4;
   localparam logic [2:0] S_LD_RD   = 3'd5;
   localparam logic [2:0] S_LD_CAP  = 3'd6;

   localparam int TW = $clog2(2 * HALF0);
   localparam logic [TW-1:0] T_LAST = TW'(2 * HALF0 - 1);
   localparam logic [TW-1:0] T_HALF = TW'(HALF0);
   localparam logic [TW-1:0] T_Q1   = TW'(HALF0 / 2);
   localparam logic [TW-1:0] T_Q3   = TW'(3 * HALF0 / 2);
   localparam logic [3:0]    B_LAST  = 4'(9 + STOP_BITS - 1);
   localparam logic [3:0]    B_STOP1 = 4'(STOP_BITS - 1);

   logic [2:0]        state;
   logic [ADDR_W-1:0] len_q;
   logic [ADDR_W-1:0] pos_nxt;
   logic [7:0]        sh;
   logic [7:0]        pf_buf;
   logic              pf_pend;
   logic [3:0]        bit_d;
   logic [TW-1:0]     tick_d;
   logic              bit_val;
   logic              level;

   // tick_d counts down through the bit; bit_d counts down through the frame
   always_comb begin
      bit_val = (bit_d == B_LAST) ? 1'b0 : sh[7];
      if (bit_val)
         level = (tick_d >= T_Q3) || ((tick_d >= T_Q1) && (tick_d < T_HALF));
      else
         level = (tick_d >= T_HALF);
      pos_nxt = pos + ADDR_W'(1);
      status  = ((state == S_LD_RD) || (state == S_LD_CAP)) ? S_RUN : state;
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state    <= S_EMPTY;
         len_q    <= '0;
         pos      <= '0;
         mem_addr <= '0;
         mem_rd   <= 1'b0;
         pf_pend  <= 1'b0;
         pf_buf   <= '0;
         sh       <= '0;
         bit_d    <= '0;
         tick_d   <= '0;
         tape_o   <= IDLE_LEVEL;
      end else if (rewind) begin
         state    <= (len == '0) ? S_EMPTY : S_STOPPED;
         len_q    <= len;
         pos      <= '0;
         mem_addr <= '0;
         mem_rd   <= 1'b0;
         pf_pend  <= 1'b0;
         pf_buf   <= '0;
         tape_o   <= IDLE_LEVEL;
      end else begin
         mem_rd  <= 1'b0;
         pf_pend <= mem_rd && ((state == S_RUN) || (state == S_PAUSED));
         if (pf_pend)
            pf_buf <= mem_data;
         case (state)
            S_EMPTY: tape_o <= IDLE_LEVEL;
            S_STOPPED: begin
               tape_o <= IDLE_LEVEL;
               if (play) begin
                  state    <= S_LD_RD;
                  mem_rd   <= 1'b1;
                  mem_addr <= pos;
               end
            end
            S_LD_RD: state <= S_LD_CAP;
            S_LD_CAP: begin
               sh    <= mem_data;
               bit_d <= B_LAST;
               // the capture edge doubles as the first tick of the start bit
               if (play && ce) begin
                  state  <= S_RUN;
                  tape_o <= 1'b1;
                  tick_d <= T_LAST - TW'(1);
               end else begin
                  state  <= play ? S_RUN : S_PAUSED;
                  tick_d <= T_LAST;
               end
            end
            S_RUN, S_PAUSED: begin
               if (ce && !play) begin
                  state <= S_PAUSED;
               end else if (ce) begin
                  state  <= S_RUN;
                  tape_o <= level;
                  if (bit_d == B_STOP1 && tick_d == T_LAST && pos_nxt < len_q) begin
                     mem_rd   <= 1'b1;
                     mem_addr <= pos_nxt;
                  end
                  if (tick_d != '0) begin
                     tick_d <= tick_d - TW'(1);
                  end else begin
                     tick_d <= T_LAST;
                     if (bit_d == '0) begin
                        if (pos_nxt == len_q) begin
                           state <= S_END;
                        end else begin
                           sh    <= pf_buf;
                           pos   <= pos_nxt;
                           bit_d <= B_LAST;
                        end
                     end else begin
                        bit_d <= bit_d - 4'd1;
                        if (bit_d != B_LAST)
                           sh <= {sh[6:0], 1'b1};
                     end
                  end
               end
            end
            S_END: tape_o <= IDLE_LEVEL;
            default: state <= S_EMPTY;
         endcase
      end
   end
endmodule

// File: tb/tb_cas_fsk_player.sv
// Directed bench for cas_fsk_player with HALF0=4, STOP_BITS=2: expected waveforms are
// built from the frame format and bit encoding, one entry per ce tick.
module tb_cas_fsk_player;
   localparam int AW = 8;
   localparam int FT = 88;

   logic          clk_sys = 1'b0;
   logic          reset, ce, play, rewind;
   logic [AW-1:0] len, mem_addr, pos;
   logic          mem_rd, tape_o;
   logic [7:0]    mem_data;
   logic [2:0]    status;
   logic [7:0]    ram [0:255];
   int            rd_q[$];
   bit            exp_q[$];
   int            n_chk = 0;
   int            n_err = 0;

   cas_fsk_player #(.ADDR_W(AW), .HALF0(4), .STOP_BITS(2), .IDLE_LEVEL(1'b0)) dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .ce      (ce),
      .play    (play),
      .rewind  (rewind),
      .len     (len),
      .mem_addr(mem_addr),
      .mem_rd  (mem_rd),
      .mem_data(mem_data),
      .tape_o  (tape_o),
      .pos     (pos),
      .status  (status)
   );

   always #5 clk_sys = ~clk_sys;
   always @(posedge clk_sys) if (mem_rd) mem_data <= ram[mem_addr];
   always @(negedge clk_sys) if (mem_rd) rd_q.push_back(int'(mem_addr));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic build_exp(input int n);
      logic [7:0]  b;
      logic [10:0] fb;
      exp_q.delete();
      for (int x = 0; x < n; x++) begin
         b  = ram[x];
         fb = {1'b0, b, 2'b11};
         for (int j = 10; j >= 0; j--)
            for (int t = 0; t < 8; t++)
               exp_q.push_back(fb[j] ? (t < 2 || (t >= 4 && t < 6)) : (t < 4));
      end
   endtask

   task automatic do_rewind(input int l, input int exp_st);
      rewind = 1'b1;
      play   = 1'b0;
      ce     = 1'b1;
      len    = AW'(l);
      @(negedge clk_sys);
      chk("rew_status", 32'(status), 32'(exp_st));
      chk("rew_pos", 32'(pos), 32'd0);
      chk("rew_tape", 32'(tape_o), 32'd0);
      chk("rew_rd", 32'(mem_rd), 32'd0);
      rewind = 1'b0;
      rd_q.delete();
   endtask

   // ticks happen on edges from the capture edge on where ce and play are both high
   task automatic run_stream(input int nt, input int nbytes, input int ce_per,
                             input int p_tick, input int p_len);
      int i = -1;
      int k = 0;
      int p_left = p_len;
      int e_pos, e_st;
      while (i < nt - 1) begin
         ce   = ((k + 1) % ce_per == 0);
         play = !((k + 1 >= 3) && (i + 1 == p_tick) && (p_left > 0));
         if (!play) p_left--;
         @(negedge clk_sys);
         k++;
         if (k >= 3 && ce && play) i++;
         if (k == 1) begin
            chk("load_rd", 32'(mem_rd), 32'd1);
            chk("load_addr", 32'(mem_addr), 32'd0);
         end
         if (i < 0) chk("tape_idle", 32'(tape_o), 32'd0);
         else chk("tape", 32'(tape_o), 32'(exp_q[i]));
         e_pos = (i < 0) ? 0 : (i + 1) / FT;
         if (e_pos > nbytes - 1) e_pos = nbytes - 1;
         chk("pos", 32'(pos), 32'(e_pos));
         if (!play && k >= 3) e_st = 3;
         else if (i == exp_q.size() - 1) e_st = 4;
         else e_st = 2;
         chk("status", 32'(status), 32'(e_st));
         if (k > 5000) begin
            chk("timeout", 32'(i), 32'(nt - 1));
            break;
         end
      end
      ce = 1'b1;
   endtask

   task automatic end_checks(input int n);
      chk("end_status", 32'(status), 32'd4);
      chk("end_pos", 32'(pos), 32'(n - 1));
      play = 1'b1;
      repeat (10) @(negedge clk_sys);
      chk("end_hold", 32'(status), 32'd4);
      chk("end_tape", 32'(tape_o), 32'd0);
      chk("rd_cnt", 32'(rd_q.size()), 32'(n));
      for (int j = 0; j < n && j < rd_q.size(); j++)
         chk("rd_addr", 32'(rd_q[j]), 32'(j));
      play = 1'b0;
   endtask

   initial begin
      reset  = 1'b1;
      ce     = 1'b1;
      play   = 1'b0;
      rewind = 1'b0;
      len    = '0;
      repeat (3) @(negedge clk_sys);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_rd", 32'(mem_rd), 32'd0);
      chk("rst_tape", 32'(tape_o), 32'd0);
      chk("rst_pos", 32'(pos), 32'd0);
      chk("rst_status", 32'(status), 32'd0);
      reset = 1'b0;

      // single byte 0xA5
      ram[0] = 8'hA5;
      do_rewind(1, 1);
      build_exp(1);
      run_stream(FT, 1, 1, -1, 0);
      end_checks(1);

      // three bytes back to back
      ram[0] = 8'h00; ram[1] = 8'hFF; ram[2] = 8'h3C;
      do_rewind(3, 1);
      build_exp(3);
      run_stream(3 * FT, 3, 1, -1, 0);
      end_checks(3);

      // pause at tick 13 of byte 0 for 50 cycles
      do_rewind(3, 1);
      run_stream(3 * FT, 3, 1, 13, 50);
      end_checks(3);

      // rewind in the middle of byte 1, then replay from byte 0
      do_rewind(3, 1);
      run_stream(100, 3, 1, -1, 0);
      do_rewind(3, 1);
      run_stream(3 * FT, 3, 1, -1, 0);
      end_checks(3);

      // ce every 4th cycle
      ram[0] = 8'hA5;
      do_rewind(1, 1);
      build_exp(1);
      run_stream(FT, 1, 4, -1, 0);
      end_checks(1);

      // empty image
      do_rewind(0, 0);
      play = 1'b1;
      repeat (20) @(negedge clk_sys);
      chk("empty_status", 32'(status), 32'd0);
      chk("empty_tape", 32'(tape_o), 32'd0);
      chk("empty_rd", 32'(rd_q.size()), 32'd0);
      play = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/cas_fsk_player.md
Name: cas_fsk_player

Overview:
- Parametrised successor to the core's cassette reader: streams a downloaded tape image from a synchronous byte RAM and regenerates the FSK tape waveform for the console's tape input.
- Adds generic address width, configurable tone timing, start/stop framing, byte prefetch (no inter-byte gap), pause/resume, end-of-file detection and position reporting.
- Sits between the tape-image RAM (written by data_io) and the console's tape-in pin. Runs on clk_sys; timing is gated by the ce input.

Parameters:
- ADDR_W, 18, width of the tape RAM address and of the length/position counters.
- HALF0, 17775, ce ticks per half-period of the '0' tone (1200 Hz at a 42.66 MHz ce rate). Must be even and ≥ 4.
- STOP_BITS, 2, number of '1' stop bits appended after each byte (1..3).
- IDLE_LEVEL, 0, level driven on tape_o when not playing.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high.
- ce  in  1  timing enable; the waveform counters advance only when ce=1.
- play  in  1  level: 1 = run, 0 = pause (motor off).
- rewind  in  1  level: while 1, the position is forced to 0 and output is idle.
- len  in  ADDR_W  image length in bytes, sampled while rewind=1.
- mem_addr  out  ADDR_W  tape RAM address.
- mem_rd  out  1  one-cycle read strobe.
- mem_data  in  8  RAM data, valid exactly 1 clk_sys after mem_rd.
- tape_o  out  1  FSK waveform.
- pos  out  ADDR_W  index of the byte currently being emitted.
- status  out  3  0=EMPTY, 1=STOPPED, 2=PLAYING, 3=PAUSED, 4=END.

Behaviour:
- Reset values:
  - mem_addr=0, mem_rd=0, tape_o=IDLE_LEVEL, pos=0, status=0.
  - Internal length register=0; prefetch buffer empty.
- States:
  - EMPTY: length=0. Stays here regardless of play.
  - STOPPED: at position 0, buffer empty, play=0.
  - LOAD: mem_rd pulse, then capture mem_data into the shift register.
  - RUN: emitting bits.
  - PAUSED: play dropped mid-stream.
  - END: last frame fully emitted.
- rewind=1 (any state, highest priority):
  - length←len, pos←0, mem_addr←0, buffer cleared, tape_o=IDLE_LEVEL.
  - Next state is EMPTY if len=0, else STOPPED.
  - Takes effect in the same cycle as reset-like clearing; any in-flight read is discarded.
- STOPPED + play=1 → LOAD:
  - Cycle 1: mem_rd=1, addr=pos.
  - Cycle 2: shift register←mem_data; enter RUN on the same cycle.
  - Latency from play rising to the first tape_o edge is 2 clk_sys.
- Frame format: start bit '0', then 8 data bits MSB first, then STOP_BITS '1' bits.
- Bit encoding, in ce ticks:
  - '0': HALF0 high, then HALF0 low (one cycle).
  - '1': HALF0/2 high, HALF0/2 low, repeated (two cycles).
  - Every bit lasts exactly 2·HALF0 ce ticks.
  - tape_o goes high on the first ce of each bit.
- Prefetch:
  - When the first stop bit begins and pos+1 < length, issue mem_rd for pos+1 and latch the result into the prefetch buffer.
  - At the frame boundary, swap the buffer into the shift register and increment pos, with no idle gap.
- End of data:
  - If pos+1 = length at the frame end, go to END: tape_o=IDLE_LEVEL, status=4.
  - END holds until rewind; play has no effect there.
- Pause:
  - play=0 during RUN → PAUSED at the next ce.
  - Bit/tick counters and tape_o are frozen; pos is held.
  - play=1 resumes on the exact frozen tick.
  - play=0 in LOAD completes the load, then pauses.
- ce=0: all counters hold. The memory handshake (mem_rd/capture) still completes on clk_sys.
- pos never exceeds length-1; mem_addr wraps to 0 only via rewind.

Test Plan:
- Sim with HALF0=4, STOP_BITS=2, len=1, byte 0xA5, rewind pulse, then play=1 with ce=1 → 11 bits × 8 ticks = 88 cycles; bit sequence 0,1,0,1,0,0,1,0,1,1,1; afterwards status=4 and tape_o=0.
- len=3, bytes 0x00,0xFF,0x3C → mem_rd pulses at addr 0,1,2; frames back-to-back with no gap; pos steps 0→1→2; END after 264 ticks.
- play dropped at tick 13 of byte 0, held 50 cycles, then raised → tape_o frozen during the pause; resumed waveform identical to an uninterrupted run shifted by 50 cycles.
- rewind asserted mid-byte 1 of 3 → same cycle: pos=0, tape_o=0, status=1. Next play restarts at byte 0.
- len=0 with rewind, then play=1 → status=0, mem_rd never asserted, tape_o=0.
- ce asserted every 4th cycle → all bit durations scale ×4; mem_rd-to-capture stays 1 clk_sys.
